// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared types and default widths for the IF/MEM memory-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_port_arbiter_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_port_wait_timer.sv
// ============================================================================
// Module      : mem_port_wait_timer
// Description : Counts bus wait cycles and flags a timeout at TIMEOUT waits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_wait,
  output logic o_timeout
);

  generate
    if (TIMEOUT > 0) begin : g_timer
      localparam int CNT_W = $clog2(TIMEOUT + 1);

      logic [CNT_W-1:0] r_cnt;

      // Fires while still waiting once TIMEOUT wait cycles have been counted.
      assign o_timeout = i_wait && (r_cnt == CNT_W'(TIMEOUT));

      always_ff @(posedge clk) begin
        if (rst) begin
          r_cnt <= '0;
        end else if (i_clear) begin
          r_cnt <= '0;
        end else if (i_wait && !o_timeout) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end else begin : g_no_timer
      logic w_unused;
      assign w_unused  = clk ^ rst ^ i_clear ^ i_wait;
      assign o_timeout = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory bus between IF fetches and MEM loads/stores.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                flush,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_wstrb,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_done,
  output logic                bus_err,
  output logic                stall_if,
  output logic                stall_mem,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_wstrb,
  input  logic                bus_ready,
  input  logic [DATA_W-1:0]   bus_rdata
);

  localparam int STRB_W = DATA_W / 8;

  arb_state_t r_state;
  arb_state_t w_next_state;

  logic              r_kill;
  logic              r_bus_req;
  logic              r_bus_we;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [DATA_W-1:0] r_bus_wdata;
  logic [STRB_W-1:0] r_bus_wstrb;
  logic              r_if_valid;
  logic [DATA_W-1:0] r_if_rdata;
  logic              r_mem_done;
  logic [DATA_W-1:0] r_mem_rdata;
  logic              r_bus_err;

  logic w_wait;
  logic w_timeout;
  logic w_complete;
  logic w_fetch_done;
  logic w_data_done;
  logic w_kill_now;
  logic w_grant_window;
  logic w_mem_elig;
  logic w_if_elig;
  logic w_grant_mem;
  logic w_grant_if;

  assign w_wait         = r_bus_req && !bus_ready;
  assign w_complete     = r_bus_req && (bus_ready || w_timeout);
  assign w_fetch_done   = w_complete && (r_state == ST_FETCH);
  assign w_data_done    = w_complete && (r_state == ST_DATA);
  assign w_kill_now     = r_kill || flush;
  assign w_grant_window = (r_state == ST_IDLE) || w_complete;

  // A requester whose transaction is completing right now is still holding its
  // request, so it must not be re-granted; a killed fetch's requester has
  // already moved on to a new address and may be served back-to-back.
  assign w_mem_elig  = mem_req && !r_mem_done && !w_data_done;
  assign w_if_elig   = if_req && !r_if_valid && !flush && !(w_fetch_done && !w_kill_now);
  assign w_grant_mem = w_grant_window && w_mem_elig;
  assign w_grant_if  = w_grant_window && !w_mem_elig && w_if_elig;

  mem_port_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_grant_mem || w_grant_if),
    .i_wait    (w_wait),
    .o_timeout (w_timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (w_grant_window) begin
      if (w_grant_mem) begin
        w_next_state = ST_DATA;
      end else if (w_grant_if) begin
        w_next_state = ST_FETCH;
      end else begin
        w_next_state = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_kill      <= 1'b0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_wstrb <= '0;
      r_if_valid  <= 1'b0;
      r_if_rdata  <= '0;
      r_mem_done  <= 1'b0;
      r_mem_rdata <= '0;
      r_bus_err   <= 1'b0;
    end else begin
      r_if_valid <= 1'b0;
      r_mem_done <= 1'b0;
      r_bus_err  <= 1'b0;

      if (w_fetch_done) begin
        r_kill <= 1'b0;
      end else if ((r_state == ST_FETCH) && flush) begin
        r_kill <= 1'b1;
      end

      if (w_fetch_done && !w_kill_now) begin
        r_if_valid <= 1'b1;
        r_bus_err  <= w_timeout;
        r_if_rdata <= w_timeout ? '0 : bus_rdata;
      end

      if (w_data_done) begin
        r_mem_done <= 1'b1;
        r_bus_err  <= w_timeout;
        if (!r_bus_we) begin
          r_mem_rdata <= w_timeout ? '0 : bus_rdata;
        end
      end

      if (w_grant_mem) begin
        r_bus_req   <= 1'b1;
        r_bus_we    <= mem_we;
        r_bus_addr  <= mem_addr;
        r_bus_wdata <= mem_wdata;
        r_bus_wstrb <= mem_wstrb;
      end else if (w_grant_if) begin
        r_bus_req   <= 1'b1;
        r_bus_we    <= 1'b0;
        r_bus_addr  <= if_addr;
        r_bus_wdata <= '0;
        r_bus_wstrb <= '0;
      end else if (w_complete) begin
        r_bus_req <= 1'b0;
      end
    end
  end

  assign stall_if  = if_req && !r_if_valid;
  assign stall_mem = mem_req && !r_mem_done;

  assign if_rdata  = r_if_rdata;
  assign if_valid  = r_if_valid;
  assign mem_rdata = r_mem_rdata;
  assign mem_done  = r_mem_done;
  assign bus_err   = r_bus_err;
  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign bus_wstrb = r_bus_wstrb;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed cycle-by-cycle vectors plus timeout/kill/reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        flush;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        bus_err;
  logic        stall_if;
  logic        stall_mem;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  int n_vec = 0;
  int n_err = 0;

  mem_port_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (15)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .flush     (flush),
    .if_rdata  (if_rdata),
    .if_valid  (if_valid),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .mem_done  (mem_done),
    .bus_err   (bus_err),
    .stall_if  (stall_if),
    .stall_mem (stall_mem),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_wstrb (bus_wstrb),
    .bus_ready (bus_ready),
    .bus_rdata (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        if_req;
    logic        flush;
    logic        mem_req;
    logic        mem_we;
    logic        rdy;
    logic [31:0] if_addr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] bus_rdata;
    logic        e_bus_req;
    logic        e_bus_we;
    logic [31:0] e_bus_addr;
    logic [31:0] e_bus_wdata;
    logic [3:0]  e_bus_wstrb;
    logic        e_if_valid;
    logic [31:0] e_if_rdata;
    logic        e_mem_done;
    logic [31:0] e_mem_rdata;
    logic        e_bus_err;
    logic        e_stall_if;
    logic        e_stall_mem;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    rst       = v.rst;
    if_req    = v.if_req;
    flush     = v.flush;
    mem_req   = v.mem_req;
    mem_we    = v.mem_we;
    bus_ready = v.rdy;
    if_addr   = v.if_addr;
    mem_addr  = v.mem_addr;
    mem_wdata = v.mem_wdata;
    mem_wstrb = v.mem_wstrb;
    bus_rdata = v.bus_rdata;
  endtask

  task automatic check_row(input int i, input vec_t v);
    chk($sformatf("r%0d.bus_req", i),   bus_req,   v.e_bus_req);
    chk($sformatf("r%0d.bus_we", i),    bus_we,    v.e_bus_we);
    chk($sformatf("r%0d.bus_addr", i),  bus_addr,  v.e_bus_addr);
    chk($sformatf("r%0d.bus_wdata", i), bus_wdata, v.e_bus_wdata);
    chk($sformatf("r%0d.bus_wstrb", i), bus_wstrb, v.e_bus_wstrb);
    chk($sformatf("r%0d.if_valid", i),  if_valid,  v.e_if_valid);
    chk($sformatf("r%0d.if_rdata", i),  if_rdata,  v.e_if_rdata);
    chk($sformatf("r%0d.mem_done", i),  mem_done,  v.e_mem_done);
    chk($sformatf("r%0d.mem_rdata", i), mem_rdata, v.e_mem_rdata);
    chk($sformatf("r%0d.bus_err", i),   bus_err,   v.e_bus_err);
    chk($sformatf("r%0d.stall_if", i),  stall_if,  v.e_stall_if);
    chk($sformatf("r%0d.stall_mem", i), stall_mem, v.e_stall_mem);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   done_c;
    bit   seen_err;
    bit   seen_valid;

    // Each row: inputs held for one cycle, outputs expected in that same cycle.
    v = '0; v.rst = 1'b1; vecs.push_back(v);
    // Plain fetch with bus_ready high
    v.rst = 1'b0; v.if_req = 1'b1; v.if_addr = 32'h100; v.rdy = 1'b1;
    v.bus_rdata = 32'h0050_0093; v.e_stall_if = 1'b1; vecs.push_back(v);
    v.e_bus_req = 1'b1; v.e_bus_addr = 32'h100; vecs.push_back(v);
    v.e_bus_req = 1'b0; v.e_if_valid = 1'b1; v.e_if_rdata = 32'h0050_0093;
    v.e_stall_if = 1'b0; vecs.push_back(v);
    v.if_req = 1'b0; v.e_if_valid = 1'b0; vecs.push_back(v);
    // Simultaneous fetch and load: load first, fetch back-to-back
    v.if_req = 1'b1; v.if_addr = 32'h104; v.mem_req = 1'b1; v.mem_addr = 32'h2000;
    v.mem_wstrb = 4'hF; v.bus_rdata = 32'hDEAD_BEEF;
    v.e_stall_if = 1'b1; v.e_stall_mem = 1'b1; vecs.push_back(v);
    v.e_bus_req = 1'b1; v.e_bus_addr = 32'h2000; v.e_bus_wstrb = 4'hF; vecs.push_back(v);
    v.bus_rdata = 32'h00A0_0113; v.e_mem_done = 1'b1; v.e_mem_rdata = 32'hDEAD_BEEF;
    v.e_bus_addr = 32'h104; v.e_bus_wstrb = 4'h0; v.e_stall_mem = 1'b0; vecs.push_back(v);
    v.mem_req = 1'b0; v.e_mem_done = 1'b0; v.e_bus_req = 1'b0; v.e_if_valid = 1'b1;
    v.e_if_rdata = 32'h00A0_0113; v.e_stall_if = 1'b0; vecs.push_back(v);
    v.if_req = 1'b0; v.e_if_valid = 1'b0; vecs.push_back(v);
    // Store with three wait cycles
    v.mem_req = 1'b1; v.mem_we = 1'b1; v.mem_addr = 32'h2004; v.mem_wdata = 32'h1234_5678;
    v.mem_wstrb = 4'b0011; v.rdy = 1'b0; v.e_stall_mem = 1'b1; vecs.push_back(v);
    v.e_bus_req = 1'b1; v.e_bus_we = 1'b1; v.e_bus_addr = 32'h2004;
    v.e_bus_wdata = 32'h1234_5678; v.e_bus_wstrb = 4'b0011;
    vecs.push_back(v); vecs.push_back(v); vecs.push_back(v);
    v.rdy = 1'b1; v.bus_rdata = 32'hCAFE_F00D; vecs.push_back(v);
    v.e_bus_req = 1'b0; v.e_mem_done = 1'b1; v.e_stall_mem = 1'b0; vecs.push_back(v);
    v.mem_req = 1'b0; v.mem_we = 1'b0; v.e_mem_done = 1'b0; vecs.push_back(v);
    // Fetch killed by flush, then redirected fetch served
    v.if_req = 1'b1; v.if_addr = 32'h1F0; v.rdy = 1'b0; v.e_stall_if = 1'b1; vecs.push_back(v);
    v.flush = 1'b1; v.e_bus_req = 1'b1; v.e_bus_we = 1'b0; v.e_bus_addr = 32'h1F0;
    v.e_bus_wdata = 32'h0; v.e_bus_wstrb = 4'h0; vecs.push_back(v);
    v.flush = 1'b0; v.if_addr = 32'h200; vecs.push_back(v);
    v.rdy = 1'b1; v.bus_rdata = 32'h1111_1111; vecs.push_back(v);
    v.bus_rdata = 32'h2222_2222; v.e_bus_addr = 32'h200; vecs.push_back(v);
    v.e_bus_req = 1'b0; v.e_if_valid = 1'b1; v.e_if_rdata = 32'h2222_2222;
    v.e_stall_if = 1'b0; vecs.push_back(v);
    v.if_req = 1'b0; v.e_if_valid = 1'b0; vecs.push_back(v);

    drive(vecs[0]);
    repeat (2) next_cycle();
    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(negedge clk);
      check_row(i, vecs[i]);
      next_cycle();
    end

    // Load against a stuck bus: timeout completion
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h3000; mem_wstrb = 4'hF;
    bus_ready = 1'b0; bus_rdata = 32'h5555_5555;
    done_c = 0; seen_err = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      next_cycle();
      @(negedge clk);
      if (c == 16) chk("to.bus_req_c16", bus_req, 1'b1);
      if (mem_done) begin
        done_c = c;
        break;
      end
      if (bus_err) seen_err = 1'b1;
    end
    chk("to.done_cycle", done_c, 17);
    chk("to.bus_err", bus_err, 1'b1);
    chk("to.mem_rdata", mem_rdata, 32'h0);
    chk("to.bus_req_drop", bus_req, 1'b0);
    chk("to.early_err", seen_err, 1'b0);
    next_cycle();
    mem_req = 1'b0;

    // Killed fetch that times out: silent
    next_cycle();
    if_req = 1'b1; if_addr = 32'h300;
    next_cycle();
    flush = 1'b1;
    next_cycle();
    flush = 1'b0; if_req = 1'b0;
    seen_err = 1'b0; seen_valid = 1'b0;
    for (int c = 2; c <= 22; c++) begin
      @(negedge clk);
      if (bus_err) seen_err = 1'b1;
      if (if_valid) seen_valid = 1'b1;
      next_cycle();
    end
    chk("kto.if_valid", seen_valid, 1'b0);
    chk("kto.bus_err", seen_err, 1'b0);
    chk("kto.bus_req", bus_req, 1'b0);
    chk("kto.if_rdata", if_rdata, 32'h2222_2222);

    // Reset during a DATA wait, then re-grant of the held request
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h4000; bus_ready = 1'b0;
    next_cycle();
    @(negedge clk);
    chk("rst.bus_req_before", bus_req, 1'b1);
    chk("rst.bus_addr_before", bus_addr, 32'h4000);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rst.bus_req", bus_req, 1'b0);
    chk("rst.mem_done", mem_done, 1'b0);
    chk("rst.bus_addr", bus_addr, 32'h0);
    chk("rst.mem_rdata", mem_rdata, 32'h0);
    next_cycle();
    bus_ready = 1'b1; bus_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    chk("rst.regrant_req", bus_req, 1'b1);
    chk("rst.regrant_addr", bus_addr, 32'h4000);
    next_cycle();
    @(negedge clk);
    chk("rst.mem_done_after", mem_done, 1'b1);
    chk("rst.mem_rdata_after", mem_rdata, 32'h0BAD_F00D);
    chk("rst.bus_err_after", bus_err, 1'b0);
    next_cycle();
    mem_req = 1'b0;
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory bus between the IF-stage instruction fetch and the MEM-stage load/store.
- Returns the stall requests that the hazard/stall logic uses to freeze the PC and the pipeline registers.
- Sits between the pipeline stages and the unified memory. MEM accesses have priority because they belong to the older instruction.
- Includes a flush-aware kill of in-flight fetches and a bus-wait timeout.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width. Byte strobe width is DATA_W/8.
- TIMEOUT, 15, maximum bus wait cycles before error completion. 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- if_req  in  1  fetch request, held until if_valid.
- if_addr  in  ADDR_W  fetch address.
- flush  in  1  branch_taken|jump; the current fetch is stale.
- if_rdata  out  DATA_W  fetched instruction.
- if_valid  out  1  one-cycle fetch completion pulse.
- mem_req  in  1  load/store request, held until mem_done.
- mem_we  in  1  1 = store.
- mem_addr  in  ADDR_W  data address.
- mem_wdata  in  DATA_W  store data.
- mem_wstrb  in  DATA_W/8  byte enables.
- mem_rdata  out  DATA_W  load data.
- mem_done  out  1  one-cycle completion pulse.
- bus_err  out  1  one-cycle pulse coincident with a completion caused by timeout.
- stall_if  out  1  IF must hold.
- stall_mem  out  1  MEM must hold.
- bus_req  out  1  bus transaction request.
- bus_we  out  1  bus write.
- bus_addr  out  ADDR_W  bus address.
- bus_wdata  out  DATA_W  bus write data.
- bus_wstrb  out  DATA_W/8  bus byte enables.
- bus_ready  in  1  bus accepts/completes in this cycle.
- bus_rdata  in  DATA_W  valid when bus_req&&bus_ready.

Behaviour:
- Reset: state=IDLE, kill=0, wait counter=0. All registered outputs are 0: bus_*, if_rdata, if_valid, mem_rdata, mem_done, bus_err.
- Reset mid-transaction abandons the bus transaction immediately (bus_req=0 next cycle). The memory must tolerate this.
- States: IDLE, FETCH, DATA.
- Bus handshake:
  - bus_req, bus_we, bus_addr, bus_wdata and bus_wstrb are registered and stable from grant until completion.
  - A transaction completes in the cycle where bus_req&&bus_ready.
  - bus_req drops the next cycle unless a new grant is issued in the completion cycle.
- Grant evaluation (IDLE, and in the completion cycle of FETCH/DATA, allowing back-to-back):
  - mem_req eligible → latch mem_* fields, go to DATA.
  - else if_req eligible && !flush → latch if_addr, go to FETCH.
  - else go to IDLE.
- Eligibility: a request is not eligible in the cycle its done pulse (mem_done/if_valid) is high. This prevents double service of a held request.
- Latency with bus_ready tied high:
  - Request at cycle 0 → bus_req at cycle 1 → completion at cycle 1 → done pulse at cycle 2.
  - Each wait cycle adds 1.
- FETCH completion:
  - If kill=0: if_rdata<=bus_rdata and if_valid<=1.
  - If kill=1: data discarded, if_valid stays 0, kill cleared.
  - kill is set by flush in any FETCH cycle, including the completion cycle itself.
- flush while IDLE or DATA has no effect on the arbiter state.
- DATA completion:
  - mem_done<=1.
  - mem_rdata<=bus_rdata for loads; unchanged for stores.
- Timeout:
  - The counter increments each cycle bus_req&&!bus_ready and clears on grant.
  - On reaching TIMEOUT, the transaction force-completes: done pulse plus bus_err=1, rdata=0.
  - A killed fetch that times out produces no if_valid and no bus_err.
- Stall outputs (combinational):
  - stall_if = if_req && !if_valid.
  - stall_mem = mem_req && !mem_done.
- Simultaneous if_req and mem_req: MEM is served first, and IF waits with stall_if=1. There is no starvation guard, because MEM issues at most one request per instruction.
- mem_wstrb=0 with mem_we=1 is still a full bus transaction.

Decomposition:
- Shared package (pipeline package): state enum {IDLE, FETCH, DATA}, default ADDR_W/DATA_W constants.
- One natural sub-module: mem_port_wait_timer. It holds the TIMEOUT counter and emits a timeout pulse, with clear-on-grant and enable-on-wait.

Test Plan:
- bus_ready=1; if_req with if_addr=0x100, bus_rdata=0x00500093 → bus_req cycle 1 with bus_addr=0x100; if_valid=1 and if_rdata=0x00500093 in cycle 2; stall_if=1 in cycles 0–1.
- if_req and mem_req (load at 0x2000, bus_rdata=0xDEADBEEF) both raised in cycle 0 → load granted first; mem_done and mem_rdata=0xDEADBEEF in cycle 2; fetch bus_req in cycle 2; if_valid in cycle 3.
- Store mem_we=1, mem_addr=0x2004, mem_wdata=0x12345678, mem_wstrb=0b0011, bus_ready held low for 3 cycles → bus_* fields stable for all 4 cycles; mem_done one cycle after completion; mem_rdata unchanged.
- Fetch in flight with bus_ready low; flush pulsed once → on completion, no if_valid; next if_req (0x200) served normally.
- bus_ready stuck at 0 with TIMEOUT=15 → after 15 wait cycles, completion with bus_err=1, mem_rdata=0, mem_done=1 in the same cycle.
- rst asserted during a DATA wait → next cycle bus_req=0, state IDLE, no mem_done; after rst deasserts, a held mem_req is re-granted.
